ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  EX->MEM pipeline register for the RV32I core; sits directly downstream of the ALU.
//  Captures the ALU result and flags, and resolves conditional branches and jumps from Z/N/C/V.
//  Issues a one-cycle PC redirect to fetch and forwards the memory and writeback fields.
//  Valid/ready handshake on both sides; supports stall (backpressure) and flush.
// PARAMETERS
//  XLEN      32  datapath width (only 32 supported)
//  RESET_PC  0   value driven on redirect_pc during reset
// PORTS
//  clk            in   1     clock
//  rst            in   1     synchronous, active-high reset
//  in_valid       in   1     EX holds a valid instruction
//  in_ready       out  1     stage can accept this cycle
//  alu_o          in   XLEN  ALU result (O)
//  alu_z/n/c/v    in   1     ALU flags Z,N,C,V; branches run ALU as A-B (switch=1, op=000)
//  is_branch      in   1     conditional branch
//  is_jump        in   1     JAL/JALR: always taken
//  funct3         in   3     branch condition select
//  target         in   XLEN  precomputed branch/jump target (JALR bit0 already cleared)
//  link_pc        in   XLEN  pc+4, written to rd for jumps instead of alu_o
//  rd_in/rd_we_in in   5/1   destination register and write enable
//  mem_rd/mem_wr  in   1/1   load/store request
//  store_data     in   XLEN  rs2 value for stores
//  flush          in   1     kill the instruction being offered and the held one
//  out_valid      out  1     MEM holds a valid instruction
//  out_ready      in   1     MEM accepts
//  result, rd, rd_we, mem_rd_o, mem_wr_o, store_data_o   out   registered copies
//  redirect_valid out  1     one-cycle pulse: fetch must load redirect_pc
//  redirect_pc    out  XLEN  redirect target
// BEHAVIOUR
//  - Reset: out_valid=0, redirect_valid=0, redirect_pc=RESET_PC; all data outputs 0.
//  - in_ready = !out_valid | out_ready (combinational; no skid buffer).
//  - Accept = in_valid & in_ready & !flush. On accept, all fields register next edge; latency 1.
//  - out_valid clears when MEM takes the held entry (out_ready) with no new accept;
//    out_valid holds when out_ready=0 (outputs stable while stalled).
//  - Condition by funct3: 000 BEQ=Z; 001 BNE=!Z; 100 BLT=N^V; 101 BGE=!(N^V);
//    110 BLTU=C; 111 BGEU=!C; 010/011 are illegal: not taken, no redirect.
//  - taken = is_jump | (is_branch & cond). On an accept with taken:
//    redirect_valid=1 and redirect_pc=target, both for exactly the following cycle.
//  - Branches: rd_we forced 0, mem_rd/mem_wr forced 0. Jumps: result=link_pc.
//  - flush: suppresses the accept and clears out_valid at the next edge
//    (when out_ready=0, the held entry is discarded). No redirect is produced.
//    flush has priority over everything except rst.
//  - in_valid with is_branch & is_jump both 1: treated as a jump.
//  - rst mid-stall: takes priority; the entry and any pending redirect are dropped.
// STRUCTURE
//  - Shared package: funct3 branch encodings (BEQ..BGEU) and XLEN.
//  - One sub-module: branch_cond (combinational; funct3 + Z,N,C,V -> cond).
//  - The rest is the register/handshake logic in this module.
// TESTING
//  1. rst=1 for 2 cycles -> out_valid=0, redirect_valid=0, redirect_pc=0, in_ready=1.
//  2. BEQ, alu_o=0, Z=1, target=0x100 -> next cycle redirect_valid=1 for 1 cycle,
//     redirect_pc=0x100, rd_we=0.
//  3. BLTU with C=1, then BGEU with C=1 -> the first redirects; the second gives no redirect.
//  4. JAL, link_pc=0x24, rd=5, target=0x80 -> result=0x24, rd_we=1, redirect to 0x80.
//  5. ALU op result 0xDEADBEEF with out_ready=0 for 3 cycles -> output stable;
//     in_ready=0; the next input is held off until out_ready=1.
//  6. Taken BNE offered with flush=1 -> no redirect, out_valid=0.
//     flush while stalled -> the held entry is dropped.

Source files
------------

// File: rtl/ex_mem_stage_pkg.sv
// Shared constants for the EX->MEM stage: datapath width, branch funct3 encodings and
// the layout of the entry held for MEM.
package ex_mem_stage_pkg;

  localparam int unsigned RV_XLEN = 32;

  typedef enum logic [2:0] {
    F3Beq  = 3'b000,
    F3Bne  = 3'b001,
    F3Blt  = 3'b100,
    F3Bge  = 3'b101,
    F3Bltu = 3'b110,
    F3Bgeu = 3'b111
  } br_funct3_e;

  typedef struct packed {
    logic [RV_XLEN-1:0] result;
    logic [4:0]         rd;
    logic               rd_we;
    logic               mem_rd;
    logic               mem_wr;
    logic [RV_XLEN-1:0] store_data;
  } mem_entry_t;

endpackage

// File: rtl/ex_mem_stage_branch_cond.sv
// Branch condition from ALU flags of A-B; C is the borrow (set when A < B unsigned).
module ex_mem_stage_branch_cond
  import ex_mem_stage_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       alu_z,
  input  logic       alu_n,
  input  logic       alu_c,
  input  logic       alu_v,
  output logic       cond
);

  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3Beq:   cond = alu_z;
      F3Bne:   cond = ~alu_z;
      F3Blt:   cond = alu_n ^ alu_v;
      F3Bge:   cond = ~(alu_n ^ alu_v);
      F3Bltu:  cond = alu_c;
      F3Bgeu:  cond = ~alu_c;
      default: cond = 1'b0; // 010/011 are not branches: never taken
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register: holds one instruction for MEM and pulses a fetch redirect
// for taken branches and jumps.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int unsigned     XLEN     = RV_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] alu_o,
  input  logic            alu_z,
  input  logic            alu_n,
  input  logic            alu_c,
  input  logic            alu_v,
  input  logic            is_branch,
  input  logic            is_jump,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] target,
  input  logic [XLEN-1:0] link_pc,
  input  logic [4:0]      rd_in,
  input  logic            rd_we_in,
  input  logic            mem_rd,
  input  logic            mem_wr,
  input  logic [XLEN-1:0] store_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            mem_rd_o,
  output logic            mem_wr_o,
  output logic [XLEN-1:0] store_data_o,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  logic            cond;
  logic            taken;
  logic            accept;
  logic            side_fx_ok;
  mem_entry_t      entry_d, entry_q;
  logic            out_valid_d, out_valid_q;
  logic            redirect_valid_d, redirect_valid_q;
  logic [XLEN-1:0] redirect_pc_d, redirect_pc_q;

  ex_mem_stage_branch_cond u_branch_cond (
    .funct3 (funct3),
    .alu_z  (alu_z),
    .alu_n  (alu_n),
    .alu_c  (alu_c),
    .alu_v  (alu_v),
    .cond   (cond)
  );

  assign taken    = is_jump | (is_branch & cond);
  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready & ~flush;
  // A pure branch never writes back or touches memory; a jump wins when both are set.
  assign side_fx_ok = is_jump | ~is_branch;

  always_comb begin
    entry_d = entry_q;
    if (accept) begin
      entry_d.result     = is_jump ? link_pc : alu_o;
      entry_d.rd         = rd_in;
      entry_d.rd_we      = rd_we_in & side_fx_ok;
      entry_d.mem_rd     = mem_rd & side_fx_ok;
      entry_d.mem_wr     = mem_wr & side_fx_ok;
      entry_d.store_data = store_data;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign redirect_valid_d = accept & taken;
  assign redirect_pc_d    = redirect_valid_d ? target : redirect_pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q          <= '0;
      out_valid_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= RESET_PC;
    end else begin
      entry_q          <= entry_d;
      out_valid_q      <= out_valid_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign result         = entry_q.result;
  assign rd             = entry_q.rd;
  assign rd_we          = entry_q.rd_we;
  assign mem_rd_o       = entry_q.mem_rd;
  assign mem_wr_o       = entry_q.mem_wr;
  assign store_data_o   = entry_q.store_data;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed literal checks plus randomized traffic compared every
// cycle against an operand-level model of the stage.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] alu_o;
  logic        alu_z, alu_n, alu_c, alu_v;
  logic        is_branch, is_jump;
  logic [2:0]  funct3;
  logic [31:0] target, link_pc, store_data;
  logic [4:0]  rd_in;
  logic        rd_we_in, mem_rd, mem_wr, flush;
  logic        out_valid, out_ready;
  logic [31:0] result, store_data_o, redirect_pc;
  logic [4:0]  rd;
  logic        rd_we, mem_rd_o, mem_wr_o, redirect_valid;

  // Operands A and B whose difference produced the flags currently being driven.
  logic [31:0] cur_a, cur_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(
    .XLEN     (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .alu_o          (alu_o),
    .alu_z          (alu_z),
    .alu_n          (alu_n),
    .alu_c          (alu_c),
    .alu_v          (alu_v),
    .is_branch      (is_branch),
    .is_jump        (is_jump),
    .funct3         (funct3),
    .target         (target),
    .link_pc        (link_pc),
    .rd_in          (rd_in),
    .rd_we_in       (rd_we_in),
    .mem_rd         (mem_rd),
    .mem_wr         (mem_wr),
    .store_data     (store_data),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .result         (result),
    .rd             (rd),
    .rd_we          (rd_we),
    .mem_rd_o       (mem_rd_o),
    .mem_wr_o       (mem_wr_o),
    .store_data_o   (store_data_o),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one offer; flags always come from A-B so branch outcomes follow the operands.
  task automatic drive(input logic v, input logic br, input logic jp, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] alu,
                       input logic [31:0] tgt, input logic [31:0] link, input logic [31:0] sd,
                       input logic [4:0] rdn, input logic we, input logic mr, input logic mw);
    logic [31:0] diff;
    diff       = a - b;
    cur_a      = a;
    cur_b      = b;
    in_valid   = v;
    is_branch  = br;
    is_jump    = jp;
    funct3     = f3;
    alu_o      = br ? diff : alu;
    alu_z      = (diff == 32'h0);
    alu_n      = diff[31];
    alu_c      = (a < b);
    alu_v      = (a[31] != b[31]) && (diff[31] != a[31]);
    target     = tgt;
    link_pc    = link;
    store_data = sd;
    rd_in      = rdn;
    rd_we_in   = we;
    mem_rd     = mr;
    mem_wr     = mw;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0,
          1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_taken(input logic br, input logic jp, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] b);
    logic c;
    case (f3)
      3'b000:  c = (a == b);
      3'b001:  c = (a != b);
      3'b100:  c = ($signed(a) < $signed(b));
      3'b101:  c = !($signed(a) < $signed(b));
      3'b110:  c = (a < b);
      3'b111:  c = !(a < b);
      default: c = 1'b0;
    endcase
    return jp || (br && c);
  endfunction

  // Reference model and per-cycle comparison.
  initial begin
    logic        m_init, m_valid, m_redir, m_zero, m_rpc_rst, acc;
    logic [31:0] m_rpc, m_res, m_sd;
    logic [4:0]  m_rd;
    logic        m_we, m_mr, m_mw;
    m_init = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_init = 1'b1; m_valid = 1'b0; m_redir = 1'b0; m_zero = 1'b1; m_rpc_rst = 1'b1;
        m_rpc = 32'h0; m_res = 32'h0; m_sd = 32'h0; m_rd = 5'd0;
        m_we = 1'b0; m_mr = 1'b0; m_mw = 1'b0;
      end else if (m_init) begin
        acc     = in_valid && (!m_valid || out_ready) && !flush;
        m_redir = acc && model_taken(is_branch, is_jump, funct3, cur_a, cur_b);
        if (m_redir) begin
          m_rpc     = target;
          m_rpc_rst = 1'b0;
        end
        if (acc) begin
          m_zero = 1'b0;
          m_res  = is_jump ? link_pc : alu_o;
          m_rd   = rd_in;
          m_we   = rd_we_in && !(is_branch && !is_jump);
          m_mr   = mem_rd && !(is_branch && !is_jump);
          m_mw   = mem_wr && !(is_branch && !is_jump);
          m_sd   = store_data;
          m_valid = 1'b1;
        end else if (out_ready) begin
          m_valid = 1'b0;
        end
        if (flush) m_valid = 1'b0;
      end
      @(negedge clk);
      if (m_init) begin
        check1("cyc_out_valid", out_valid, m_valid);
        check1("cyc_in_ready", in_ready, !m_valid || out_ready);
        check1("cyc_redirect_valid", redirect_valid, m_redir);
        if (m_redir || m_rpc_rst) check32("cyc_redirect_pc", redirect_pc, m_rpc);
        if (m_valid || m_zero) begin
          check32("cyc_result", result, m_res);
          check32("cyc_rd", {27'h0, rd}, {27'h0, m_rd});
          check1("cyc_rd_we", rd_we, m_we);
          check1("cyc_mem_rd", mem_rd_o, m_mr);
          check1("cyc_mem_wr", mem_wr_o, m_mw);
          check32("cyc_store_data", store_data_o, m_sd);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Stimulus with literal expectations.
  initial begin
    logic [31:0] a, b;
    logic        br, jp;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    idle();
    step(); step();
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_redirect_valid", redirect_valid, 1'b0);
    check32("rst_redirect_pc", redirect_pc, 32'h0);
    check1("rst_in_ready", in_ready, 1'b1);
    check32("rst_result", result, 32'h0);
    rst = 1'b0;

    // BEQ taken
    drive(1, 1, 0, 3'b000, 32'd5, 32'd5, 32'h0, 32'h100, 32'h4, 32'h0, 5'd1, 1, 0, 0);
    step();
    check1("beq_redirect_valid", redirect_valid, 1'b1);
    check32("beq_redirect_pc", redirect_pc, 32'h100);
    check1("beq_rd_we", rd_we, 1'b0);
    check32("beq_result", result, 32'h0);
    idle();
    step();
    check1("beq_pulse_once", redirect_valid, 1'b0);
    check1("beq_drained", out_valid, 1'b0);

    // BLTU taken then BGEU not taken, both with C=1
    drive(1, 1, 0, 3'b110, 32'd1, 32'd2, 32'h0, 32'h200, 32'h0, 32'h0, 5'd2, 0, 0, 0);
    step();
    check1("bltu_redirect_valid", redirect_valid, 1'b1);
    check32("bltu_redirect_pc", redirect_pc, 32'h200);
    drive(1, 1, 0, 3'b111, 32'd1, 32'd2, 32'h0, 32'h300, 32'h0, 32'h0, 5'd2, 0, 0, 0);
    step();
    check1("bgeu_no_redirect", redirect_valid, 1'b0);
    check1("bgeu_out_valid", out_valid, 1'b1);

    // JAL
    drive(1, 0, 1, 3'b000, 32'h0, 32'h0, 32'h0, 32'h80, 32'h24, 32'h0, 5'd5, 1, 0, 0);
    step();
    check32("jal_result", result, 32'h24);
    check32("jal_rd", {27'h0, rd}, 32'd5);
    check1("jal_rd_we", rd_we, 1'b1);
    check1("jal_redirect_valid", redirect_valid, 1'b1);
    check32("jal_redirect_pc", redirect_pc, 32'h80);

    // Stall: output held, next input blocked
    drive(1, 0, 0, 3'b000, 32'd7, 32'd3, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 5'd3, 1, 0, 0);
    step();
    out_ready = 1'b0;
    drive(1, 0, 0, 3'b000, 32'd7, 32'd3, 32'h12345678, 32'h0, 32'h0, 32'h0, 5'd4, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check32("stall_result", result, 32'hDEADBEEF);
      check1("stall_in_ready", in_ready, 1'b0);
      check1("stall_out_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    step();
    check32("unstall_result", result, 32'h12345678);
    check32("unstall_rd", {27'h0, rd}, 32'd4);
    idle();
    step();
    check1("unstall_drained", out_valid, 1'b0);

    // Flush of a taken BNE
    drive(1, 1, 0, 3'b001, 32'd1, 32'd2, 32'h0, 32'h400, 32'h0, 32'h0, 5'd0, 0, 0, 0);
    flush = 1'b1;
    step();
    check1("flush_no_redirect", redirect_valid, 1'b0);
    check1("flush_out_valid", out_valid, 1'b0);
    flush = 1'b0;

    // Flush drops a stalled entry
    drive(1, 0, 0, 3'b000, 32'd0, 32'd0, 32'h55, 32'h0, 32'h0, 32'hA5, 5'd6, 0, 0, 1);
    out_ready = 1'b0;
    step();
    check1("held_out_valid", out_valid, 1'b1);
    check1("held_mem_wr", mem_wr_o, 1'b1);
    check32("held_store_data", store_data_o, 32'hA5);
    idle();
    flush = 1'b1;
    step();
    check1("flush_stalled_dropped", out_valid, 1'b0);
    flush = 1'b0;
    out_ready = 1'b1;

    // Branch and jump together act as a jump; illegal funct3 never redirects
    drive(1, 1, 1, 3'b010, 32'd9, 32'd9, 32'h0, 32'h500, 32'h44, 32'h0, 5'd7, 1, 0, 0);
    step();
    check1("both_redirect_valid", redirect_valid, 1'b1);
    check32("both_redirect_pc", redirect_pc, 32'h500);
    check32("both_result", result, 32'h44);
    check1("both_rd_we", rd_we, 1'b1);
    drive(1, 1, 0, 3'b011, 32'd9, 32'd9, 32'h0, 32'h600, 32'h0, 32'h0, 5'd7, 1, 0, 0);
    step();
    check1("illegal_no_redirect", redirect_valid, 1'b0);
    check1("illegal_rd_we", rd_we, 1'b0);

    // Reset while stalled with a redirect pending
    drive(1, 0, 1, 3'b000, 32'h0, 32'h0, 32'h0, 32'h700, 32'h8, 32'h0, 5'd1, 1, 0, 0);
    step();
    check1("pre_rst_redirect", redirect_valid, 1'b1);
    out_ready = 1'b0;
    idle();
    rst = 1'b1;
    step();
    check1("rst_stall_out_valid", out_valid, 1'b0);
    check1("rst_stall_redirect", redirect_valid, 1'b0);
    check32("rst_stall_redirect_pc", redirect_pc, 32'h0);
    rst = 1'b0;
    out_ready = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ 32'h8000_0000;
        2:       b = a + $urandom_range(0, 3) - 32'd1;
        default: b = $urandom;
      endcase
      br = ($urandom_range(0, 99) < 45);
      jp = ($urandom_range(0, 99) < 12);
      drive($urandom_range(0, 99) < 75, br, jp, 3'($urandom_range(0, 7)), a, b, $urandom,
            $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 99) < 65);
      flush     = ($urandom_range(0, 99) < 8);
      rst       = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; flush = 1'b0;
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
